// File: rtl/controller_nios2_qsys_0_oci_trace_monitor.sv
// controller_nios2_qsys_0_oci_trace_monitor
// Captures trace words whenever dct_count changes, buffers them in a show-ahead
// FIFO, and walks CAPTURE -> DRAIN -> DONE as the test winds down.
// Build option: define OCI_TRACE_OVERWRITE_EN to overwrite the oldest entry on a
// full push; by default the incoming word is dropped instead.
module controller_nios2_qsys_0_oci_trace_monitor #(
   parameter int DATA_W = 30,
   parameter int CNT_W  = 4,
   parameter int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] dct_buffer,
   input  logic [CNT_W-1:0]  dct_count,
   input  logic              test_ending,
   input  logic              test_has_ended,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic [15:0]       drop_count,
   output logic              done
);

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      DRAIN   = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  prev_count;
   logic [ADDR_W:0]   level_nxt;
   logic              full;
   logic              push_req;
   logic              pop;
   logic              full_push;
   logic              wr_en;
   logic              rd_adv;

   // Saturating increment for the lost-word counter
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign full      = (level == LEVEL_FULL);
   assign rd_valid  = (level != '0);
   assign rd_data   = mem[rd_ptr];
   assign push_req  = (dct_count != prev_count) && (state == CAPTURE);
   assign pop       = rd_valid && rd_ready;
   // A full push with a simultaneous pop has room, so it is not a loss
   assign full_push = push_req && full && !pop;

`ifdef OCI_TRACE_OVERWRITE_EN
   // Overwrite policy: every push writes; a full push evicts the oldest word
   assign wr_en  = push_req;
   assign rd_adv = pop || full_push;
`else
   // Drop policy: a full push without a pop leaves the FIFO untouched
   assign wr_en  = push_req && !full_push;
   assign rd_adv = pop;
`endif

   // Post-update occupancy, also used by the DRAIN exit test
   always_comb begin
      level_nxt = level;
      if (push_req && !pop && !full) begin
         level_nxt = level + LEVEL_ONE;
      end else if (pop && !push_req) begin
         level_nxt = level - LEVEL_ONE;
      end
   end

   // Trace storage: written without reset, contents are don't-care while empty
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= dct_buffer;
      end
   end

   // Pointers, occupancy and change detection on dct_count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         prev_count <= '0;
      end else begin
         prev_count <= dct_count;
         level      <= level_nxt;
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_adv) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Sticky overflow flag and saturating count of lost words
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (full_push) begin
         overflow   <= 1'b1;
         drop_count <= sat_inc16(drop_count);
      end
   end

   // Capture/drain/done sequencing with a registered done flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= CAPTURE;
         done  <= 1'b0;
      end else begin
         case (state)
            CAPTURE: begin
               if (test_ending || test_has_ended) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if ((level_nxt == '0) && test_has_ended) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done <= 1'b1;
            end
            default: begin
               state <= CAPTURE;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_controller_nios2_qsys_0_oci_trace_monitor.sv
// Testbench for controller_nios2_qsys_0_oci_trace_monitor: directed vector table,
// hand-written corner sequences and randomized traffic against a queue model.
module tb_controller_nios2_qsys_0_oci_trace_monitor;

   localparam int DATA_W = 30;
   localparam int CNT_W  = 4;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [DATA_W-1:0] dct_buffer = '0;
   logic [CNT_W-1:0]  dct_count = '0;
   logic              test_ending = 1'b0;
   logic              test_has_ended = 1'b0;
   logic              rd_ready = 1'b0;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic [15:0]       drop_count;
   logic              done;

   controller_nios2_qsys_0_oci_trace_monitor #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .overflow(overflow),
      .drop_count(drop_count), .done(done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int c     = 0;

   // Behavioural model: a word queue plus a few flags
   logic [DATA_W-1:0] q[$];
   logic [CNT_W-1:0]  m_prev;
   bit                m_stop;
   bit                m_done;
   bit                m_ovf;
   int                m_drop;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_prev = '0;
      m_stop = 0;
      m_done = 0;
      m_ovf  = 0;
      m_drop = 0;
   endfunction

   function automatic void model_step();
      bit push;
      bit pop;
      push = (dct_count != m_prev) && !m_stop;
      pop  = (q.size() != 0) && rd_ready;
      if (push && !pop && q.size() == DEPTH) begin
         m_ovf = 1;
         if (m_drop < 65535) m_drop++;
`ifdef OCI_TRACE_OVERWRITE_EN
         void'(q.pop_front());
         q.push_back(dct_buffer);
`endif
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(dct_buffer);
      end
      m_prev = dct_count;
      if (!m_stop) begin
         if (test_ending || test_has_ended) m_stop = 1;
      end else if (!m_done && test_has_ended && q.size() == 0) begin
         m_done = 1;
      end
   endfunction

   task automatic model_check(input string pfx);
      check({pfx, ".valid"}, 32'(rd_valid), 32'(q.size() != 0));
      check({pfx, ".level"}, 32'(level), 32'(q.size()));
      if (q.size() != 0) check({pfx, ".data"}, 32'(rd_data), 32'(q[0]));
      check({pfx, ".ovf"}, 32'(overflow), 32'(m_ovf));
      check({pfx, ".drop"}, 32'(drop_count), 32'(m_drop));
      check({pfx, ".done"}, 32'(done), 32'(m_done));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      dct_count      = '0;
      dct_buffer     = '0;
      test_ending    = 1'b0;
      test_has_ended = 1'b0;
      rd_ready       = 1'b0;
      reset_n        = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      c = 0;
      model_reset();
   endtask

   task automatic push_word(input logic [DATA_W-1:0] w, input logic rdy);
      c++;
      dct_count  = c[CNT_W-1:0];
      dct_buffer = w;
      rd_ready   = rdy;
      tick();
   endtask

   typedef struct {
      logic [CNT_W-1:0]  cnt;
      logic [DATA_W-1:0] wd;
      logic              te;
      logic              the;
      logic              rdy;
      logic              e_valid;
      logic [ADDR_W:0]   e_level;
      logic [DATA_W-1:0] e_data;
      logic              e_done;
   } vec_t;

   vec_t vt[10];

   initial begin
      logic [DATA_W-1:0] exp_head;
      int bias;

      // Directed vectors from reset: capture, push+pop, stop, drain, done
      vt[0] = '{4'd1, 30'h0000ABCD, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 30'h0000ABCD, 1'b0};
      vt[1] = '{4'd1, 30'h00001234, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 30'h0000ABCD, 1'b0};
      vt[2] = '{4'd2, 30'h00001111, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 30'h0000ABCD, 1'b0};
      vt[3] = '{4'd3, 30'h00002222, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 30'h00001111, 1'b0};
      vt[4] = '{4'd3, 30'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 30'h00002222, 1'b0};
      vt[5] = '{4'd4, 30'h00003333, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 30'h00002222, 1'b0};
      vt[6] = '{4'd5, 30'h00004444, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 30'h00002222, 1'b0};
      vt[7] = '{4'd6, 30'h00005555, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 30'h00003333, 1'b0};
      vt[8] = '{4'd6, 30'h00005555, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 30'h00000000, 1'b1};
      vt[9] = '{4'd7, 30'h00006666, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 30'h00000000, 1'b1};

      apply_reset();
      check("rst.valid", 32'(rd_valid), 32'd0);
      check("rst.level", 32'(level), 32'd0);
      check("rst.ovf", 32'(overflow), 32'd0);
      check("rst.drop", 32'(drop_count), 32'd0);
      check("rst.done", 32'(done), 32'd0);

      for (int i = 0; i < 10; i++) begin
         dct_count      = vt[i].cnt;
         dct_buffer     = vt[i].wd;
         test_ending    = vt[i].te;
         test_has_ended = vt[i].the;
         rd_ready       = vt[i].rdy;
         tick();
         check($sformatf("vec%0d.valid", i), 32'(rd_valid), 32'(vt[i].e_valid));
         check($sformatf("vec%0d.level", i), 32'(level), 32'(vt[i].e_level));
         if (vt[i].e_valid) check($sformatf("vec%0d.data", i), 32'(rd_data), 32'(vt[i].e_data));
         check($sformatf("vec%0d.done", i), 32'(done), 32'(vt[i].e_done));
      end

      // Full FIFO followed by one more push without a pop
      apply_reset();
      for (int i = 1; i <= 16; i++) push_word(DATA_W'(i), 1'b0);
      check("fill16.level", 32'(level), 32'd16);
      check("fill16.ovf", 32'(overflow), 32'd0);
      push_word(30'h11, 1'b0);
`ifdef OCI_TRACE_OVERWRITE_EN
      exp_head = 30'd2;
`else
      exp_head = 30'd1;
`endif
      check("ovf17.level", 32'(level), 32'd16);
      check("ovf17.ovf", 32'(overflow), 32'd1);
      check("ovf17.drop", 32'(drop_count), 32'd1);
      check("ovf17.head", 32'(rd_data), 32'(exp_head));

      // Full FIFO with simultaneous push and pop loses nothing
      apply_reset();
      for (int i = 1; i <= 16; i++) push_word(DATA_W'(i), 1'b0);
      push_word(30'h22, 1'b1);
      check("pp.level", 32'(level), 32'd16);
      check("pp.ovf", 32'(overflow), 32'd0);
      check("pp.drop", 32'(drop_count), 32'd0);
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("pp.rd%0d", i), 32'(rd_data), (i == 15) ? 32'h22 : 32'(i + 2));
         tick();
      end
      check("pp.empty", 32'(level), 32'd0);

      // Stop capture, keep changing counts, then drain to DONE
      apply_reset();
      push_word(30'hA1, 1'b0);
      push_word(30'hA2, 1'b0);
      push_word(30'hA3, 1'b0);
      test_ending = 1'b1;
      tick();
      test_ending = 1'b0;
      push_word(30'hB1, 1'b0);
      push_word(30'hB2, 1'b0);
      check("drain.level", 32'(level), 32'd3);
      test_has_ended = 1'b1;
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("drain.rd%0d", i), 32'(rd_data), 32'(32'hA1 + i));
         check($sformatf("drain.done%0d", i), 32'(done), 32'd0);
         tick();
      end
      check("drain.empty", 32'(rd_valid), 32'd0);
      check("drain.done", 32'(done), 32'd1);
      tick();
      check("drain.hold", 32'(done), 32'd1);

      // Reset in the middle of operation discards queued words
      apply_reset();
      for (int i = 1; i <= 5; i++) push_word(DATA_W'(i), 1'b0);
      check("mid.level5", 32'(level), 32'd5);
      dct_count = '0;
      c = 0;
      reset_n = 1'b0;
      #1;
      check("mid.async", 32'(level), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      check("mid.level", 32'(level), 32'd0);
      check("mid.valid", 32'(rd_valid), 32'd0);
      check("mid.drop", 32'(drop_count), 32'd0);
      check("mid.done", 32'(done), 32'd0);
      for (int i = 0; i < 3; i++) tick();
      check("mid.nopush", 32'(level), 32'd0);
      push_word(30'h77, 1'b0);
      check("mid.capture", 32'(level), 32'd1);
      check("mid.data", 32'(rd_data), 32'h77);

      // Drop counter saturation
      apply_reset();
      for (int i = 1; i <= 16; i++) push_word(DATA_W'(i), 1'b0);
      for (int i = 0; i < 65540; i++) push_word(DATA_W'($urandom), 1'b0);
      check("sat.drop", 32'(drop_count), 32'hFFFF);
      check("sat.ovf", 32'(overflow), 32'd1);
      check("sat.level", 32'(level), 32'd16);

      // Randomized traffic against the model
      apply_reset();
      bias = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 400 == 0) bias = $urandom_range(5, 95);
         if ($urandom_range(0, 499) == 0 || (m_done && $urandom_range(0, 9) == 0)) begin
            apply_reset();
            model_check("rnd.rst");
         end else begin
            if ($urandom_range(0, 2) != 0) c++;
            dct_count      = c[CNT_W-1:0];
            dct_buffer     = DATA_W'($urandom);
            test_ending    = ($urandom_range(0, 299) == 0);
            test_has_ended = m_stop ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 599) == 0);
            rd_ready       = ($urandom_range(0, 99) < bias);
            tick();
            model_check("rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/controller_nios2_qsys_0_oci_trace_monitor.md
CONTROLLER_NIOS2_QSYS_0_OCI_TRACE_MONITOR -- requirements
Module: controller_nios2_qsys_0_oci_trace_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 30: trace word width.
REQ-002 SHALL have parameter CNT_W, default 4: trace count width.
REQ-003 SHALL have parameter DEPTH, default 16: FIFO entries, power of 2, minimum 2; ADDR_W = log2(DEPTH).
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: async active-low reset.
REQ-007 SHALL have port dct_buffer, input, DATA_W bits: trace word.
REQ-008 SHALL have port dct_count, input, CNT_W bits: trace count; a change marks a new word.
REQ-009 SHALL have port test_ending, input, 1 bit: stop capture.
REQ-010 SHALL have port test_has_ended, input, 1 bit: test complete.
REQ-011 SHALL have port rd_ready, input, 1 bit: consumer accepts the head word.
REQ-012 SHALL have port rd_valid, output, 1 bit: head word available.
REQ-013 SHALL have port rd_data, output, DATA_W bits: head word.
REQ-014 SHALL have port level, output, ADDR_W+1 bits: current occupancy.
REQ-015 SHALL have port overflow, output, 1 bit: sticky; set when a word is lost.
REQ-016 SHALL have port drop_count, output, 16 bits: lost words, saturating.
REQ-017 SHALL have port done, output, 1 bit: high in state DONE.

Function
REQ-018 SHALL register dct_count into prev_count every cycle; push request = (dct_count != prev_count) AND state==CAPTURE.
REQ-019 SHALL write the dct_buffer value present in the push-request cycle; the word SHALL be visible on rd_data/rd_valid the next cycle (1-cycle latency into an empty FIFO).
REQ-020 SHALL use show-ahead reads: rd_valid = (level != 0); pop = rd_valid AND rd_ready; rd_data = entry at the read pointer.
REQ-021 SHALL wrap read and write pointers modulo DEPTH; level SHALL range 0..DEPTH.
REQ-022 SHALL, on push and pop in the same cycle, perform both with level unchanged, including when full (no loss).
REQ-023 SHALL, on push with level==DEPTH and no pop, apply the overflow policy of REQ-031/032, set overflow, and increment drop_count (saturating at 0xFFFF).
REQ-024 SHALL have FSM states CAPTURE, DRAIN, DONE; CAPTURE is the reset state.
REQ-025 SHALL transition CAPTURE->DRAIN when test_ending OR test_has_ended is asserted; a push request in that same cycle SHALL still be captured.
REQ-026 SHALL, in DRAIN, not capture; pops continue; DRAIN->DONE when level==0 AND test_has_ended, evaluated on the post-pop level of the same cycle (a pop of the last word plus test_has_ended reaches DONE the next cycle).
REQ-027 SHALL hold DONE until reset; done=1 only in DONE; pops are ignored in DONE because level is 0.

Reset
REQ-028 SHALL, while reset_n=0, clear level, both pointers, prev_count, overflow, drop_count, rd_valid, and done, and set state=CAPTURE.
REQ-029 SHALL not reset the storage array; rd_data is don't-care while rd_valid=0.
REQ-030 SHALL, on reset assertion mid-operation, discard all queued words; the first post-reset push requires dct_count to differ from 0.

Configuration
REQ-031 SHALL, when OCI_TRACE_OVERWRITE_EN is defined, on a full push (REQ-023) overwrite the oldest entry and advance the read pointer, with level staying DEPTH and the newest word retained.
REQ-032 SHALL, when OCI_TRACE_OVERWRITE_EN is undefined, drop the incoming word on a full push, leaving the FIFO contents unchanged.

Verification
REQ-033 SHALL cover: after reset, dct_count 0->1 with dct_buffer=0x0000ABCD, rd_ready=0 -> next cycle rd_valid=1, rd_data=0x0000ABCD, level=1.
REQ-034 SHALL cover: 16 count changes, words 1..16, rd_ready=0, then a 17th with word 0x11 -> level=16, overflow=1, drop_count=1; head=1 without the macro, head=2 with OCI_TRACE_OVERWRITE_EN.
REQ-035 SHALL cover: full FIFO, simultaneous push of 0x22 and pop -> level=16, overflow=0, 0x22 emerges last.
REQ-036 SHALL cover: 3 words queued, test_ending pulse, further count changes, then test_has_ended=1 and rd_ready=1 -> exactly 3 words read, done=1 one cycle after the last pop.
REQ-037 SHALL cover: 5 words queued, reset_n low for 1 cycle -> level=0, rd_valid=0, drop_count=0, state CAPTURE; dct_count held at 0 -> no push.
REQ-038 SHALL cover: 65540 overflowing pushes -> drop_count=0xFFFF.
